// File: rtl/int_mode_sequencer.sv
// Interrupt mode / IFF state and the interrupt acceptance sequencer that drives
// ACK, PC push, optional mode-2 vector table read and the final jump request.
module int_mode_sequencer #(
  parameter logic [15:0] NMI_VECTOR = 16'h0066,
  parameter logic [15:0] RST_VECTOR = 16'h0038
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        P2_IM0,
  input  logic        P2_IM1,
  input  logic        P2_IM2,
  input  logic        ei,
  input  logic        di,
  input  logic        retn,
  input  logic        int_req,
  input  logic        nmi_req,
  input  logic        boundary,
  input  logic [15:0] pc_in,
  input  logic [7:0]  i_reg,
  input  logic        bus_done,
  input  logic [7:0]  bus_rdata,
  output logic [1:0]  im_mode,
  output logic        iff1,
  output logic        iff2,
  output logic        busy,
  output logic        bus_req,
  output logic [2:0]  bus_op,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        jump_valid,
  output logic [15:0] jump_addr,
  output logic        exec_valid,
  output logic [7:0]  exec_opcode
);

  typedef enum logic [2:0] {
    IDLE, ACK, PUSH_HI, PUSH_LO, RD_LO, RD_HI, JUMP
  } state_t;

  localparam logic [2:0] OP_ACK = 3'd0;
  localparam logic [2:0] OP_PHI = 3'd1;
  localparam logic [2:0] OP_PLO = 3'd2;
  localparam logic [2:0] OP_RD  = 3'd3;

  state_t      state_q, state_d;
  logic [1:0]  im_q, im_d;
  logic [1:0]  mode_q, mode_d;
  logic        iff1_q, iff1_d, iff2_q, iff2_d;
  logic        nmi_hist_q, nmi_hist_d, nmi_pend_q, nmi_pend_d;
  logic        ei_blk_q, ei_blk_d;
  logic        is_nmi_q, is_nmi_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  vec_q, vec_d, lo_q, lo_d;
  logic        bus_req_q, bus_req_d;
  logic [2:0]  bus_op_q, bus_op_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        jump_valid_q, jump_valid_d;
  logic [15:0] jump_addr_q, jump_addr_d;
  logic        exec_valid_q, exec_valid_d;
  logic [7:0]  exec_opcode_q, exec_opcode_d;
  logic        nmi_edge;

  assign nmi_edge = nmi_req & ~nmi_hist_q;

  always_comb begin
    state_d       = state_q;
    im_d          = im_q;
    mode_d        = mode_q;
    iff1_d        = iff1_q;
    iff2_d        = iff2_q;
    nmi_hist_d    = nmi_req;
    nmi_pend_d    = nmi_pend_q | nmi_edge;
    ei_blk_d      = ei_blk_q;
    is_nmi_d      = is_nmi_q;
    pc_d          = pc_q;
    vec_d         = vec_q;
    lo_d          = lo_q;
    bus_req_d     = bus_req_q;
    bus_op_d      = bus_op_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    jump_valid_d  = 1'b0;
    jump_addr_d   = jump_addr_q;
    exec_valid_d  = 1'b0;
    exec_opcode_d = exec_opcode_q;

    if (P2_IM2)      im_d = 2'd2;
    else if (P2_IM1) im_d = 2'd1;
    else if (P2_IM0) im_d = 2'd0;

    if (retn) iff1_d = iff2_q;
    if (ei) begin
      iff1_d = 1'b1;
      iff2_d = 1'b1;
    end
    if (di) begin
      iff1_d = 1'b0;
      iff2_d = 1'b0;
    end

    // EI-block survives the boundary of EI itself and clears on the next one
    if (ei)            ei_blk_d = 1'b1;
    else if (boundary) ei_blk_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (boundary && nmi_pend_q) begin
          iff2_d     = iff1_q;
          iff1_d     = 1'b0;
          nmi_pend_d = nmi_edge;
          is_nmi_d   = 1'b1;
          pc_d       = pc_in;
          state_d    = PUSH_HI;
        end else if (boundary && int_req && iff1_q && !ei_blk_q) begin
          iff1_d   = 1'b0;
          iff2_d   = 1'b0;
          is_nmi_d = 1'b0;
          mode_d   = im_q;
          pc_d     = pc_in;
          state_d  = ACK;
        end
      end
      ACK: begin
        if (!bus_req_q) begin
          bus_req_d = 1'b1;
          bus_op_d  = OP_ACK;
        end else if (bus_done) begin
          bus_req_d = 1'b0;
          vec_d     = bus_rdata;
          if (mode_q == 2'd0) begin
            exec_valid_d  = 1'b1;
            exec_opcode_d = bus_rdata;
            state_d       = IDLE;
          end else begin
            state_d = PUSH_HI;
          end
        end
      end
      PUSH_HI: begin
        if (!bus_req_q) begin
          bus_req_d   = 1'b1;
          bus_op_d    = OP_PHI;
          bus_wdata_d = pc_q[15:8];
        end else if (bus_done) begin
          bus_req_d = 1'b0;
          state_d   = PUSH_LO;
        end
      end
      PUSH_LO: begin
        if (!bus_req_q) begin
          bus_req_d   = 1'b1;
          bus_op_d    = OP_PLO;
          bus_wdata_d = pc_q[7:0];
        end else if (bus_done) begin
          bus_req_d = 1'b0;
          if (is_nmi_q) begin
            jump_addr_d  = NMI_VECTOR;
            jump_valid_d = 1'b1;
            state_d      = JUMP;
          end else if (mode_q == 2'd1) begin
            jump_addr_d  = RST_VECTOR;
            jump_valid_d = 1'b1;
            state_d      = JUMP;
          end else begin
            state_d = RD_LO;
          end
        end
      end
      RD_LO: begin
        if (!bus_req_q) begin
          bus_req_d  = 1'b1;
          bus_op_d   = OP_RD;
          bus_addr_d = {i_reg, vec_q};
        end else if (bus_done) begin
          bus_req_d = 1'b0;
          lo_d      = bus_rdata;
          state_d   = RD_HI;
        end
      end
      RD_HI: begin
        if (!bus_req_q) begin
          bus_req_d  = 1'b1;
          bus_op_d   = OP_RD;
          bus_addr_d = {i_reg, vec_q} + 16'd1;
        end else if (bus_done) begin
          bus_req_d    = 1'b0;
          jump_addr_d  = {bus_rdata, lo_q};
          jump_valid_d = 1'b1;
          state_d      = JUMP;
        end
      end
      JUMP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      im_q          <= 2'd0;
      mode_q        <= 2'd0;
      iff1_q        <= 1'b0;
      iff2_q        <= 1'b0;
      nmi_hist_q    <= 1'b0;
      nmi_pend_q    <= 1'b0;
      ei_blk_q      <= 1'b0;
      is_nmi_q      <= 1'b0;
      pc_q          <= 16'd0;
      vec_q         <= 8'd0;
      lo_q          <= 8'd0;
      bus_req_q     <= 1'b0;
      bus_op_q      <= 3'd0;
      bus_addr_q    <= 16'd0;
      bus_wdata_q   <= 8'd0;
      jump_valid_q  <= 1'b0;
      jump_addr_q   <= 16'd0;
      exec_valid_q  <= 1'b0;
      exec_opcode_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      im_q          <= im_d;
      mode_q        <= mode_d;
      iff1_q        <= iff1_d;
      iff2_q        <= iff2_d;
      nmi_hist_q    <= nmi_hist_d;
      nmi_pend_q    <= nmi_pend_d;
      ei_blk_q      <= ei_blk_d;
      is_nmi_q      <= is_nmi_d;
      pc_q          <= pc_d;
      vec_q         <= vec_d;
      lo_q          <= lo_d;
      bus_req_q     <= bus_req_d;
      bus_op_q      <= bus_op_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      jump_valid_q  <= jump_valid_d;
      jump_addr_q   <= jump_addr_d;
      exec_valid_q  <= exec_valid_d;
      exec_opcode_q <= exec_opcode_d;
    end
  end

  assign im_mode     = im_q;
  assign iff1        = iff1_q;
  assign iff2        = iff2_q;
  assign busy        = (state_q != IDLE);
  assign bus_req     = bus_req_q;
  assign bus_op      = bus_op_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign jump_valid  = jump_valid_q;
  assign jump_addr   = jump_addr_q;
  assign exec_valid  = exec_valid_q;
  assign exec_opcode = exec_opcode_q;

endmodule

// File: tb/tb_int_mode_sequencer.sv
// Bench for int_mode_sequencer: table vectors for mode/IFF strobes, hand-written
// interrupt sequences, and randomized sequences against a transaction-list model.
module tb_int_mode_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        P2_IM0 = 0, P2_IM1 = 0, P2_IM2 = 0;
  logic        ei = 0, di = 0, retn = 0;
  logic        int_req = 0, nmi_req = 0, boundary = 0;
  logic [15:0] pc_in = 16'd0;
  logic [7:0]  i_reg = 8'd0;
  logic        bus_done = 0;
  logic [7:0]  bus_rdata = 8'd0;
  logic [1:0]  im_mode;
  logic        iff1, iff2, busy, bus_req;
  logic [2:0]  bus_op;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        jump_valid;
  logic [15:0] jump_addr;
  logic        exec_valid;
  logic [7:0]  exec_opcode;

  int errors = 0;
  int checks = 0;

  int_mode_sequencer dut (
    .clock(clock), .reset(reset),
    .P2_IM0(P2_IM0), .P2_IM1(P2_IM1), .P2_IM2(P2_IM2),
    .ei(ei), .di(di), .retn(retn),
    .int_req(int_req), .nmi_req(nmi_req), .boundary(boundary),
    .pc_in(pc_in), .i_reg(i_reg), .bus_done(bus_done), .bus_rdata(bus_rdata),
    .im_mode(im_mode), .iff1(iff1), .iff2(iff2), .busy(busy),
    .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
    .exec_valid(exec_valid), .exec_opcode(exec_opcode)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic im0, im1, im2, s_ei, s_di;
    logic [1:0] mode;
    logic f1, f2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    P2_IM0 = (m == 2'd0);
    P2_IM1 = (m == 2'd1);
    P2_IM2 = (m == 2'd2);
    step();
    P2_IM0 = 0; P2_IM1 = 0; P2_IM2 = 0;
  endtask

  task automatic enable_ints();
    ei = 1;
    step();
    ei = 0;
    boundary = 1;
    step();
    boundary = 0;
  endtask

  // Acts as the bus unit after acceptance, collecting transactions and comparing
  // them with the list the interrupt rules predict.
  task automatic serve(input bit nmi, input logic [1:0] mode, input logic [15:0] pc,
                       input logic [7:0] ireg, input logic [7:0] vec, input logic [7:0] lo,
                       input logic [7:0] hi, input int lat, input int abort_txn);
    int exp_op[$];
    int exp_val[$];
    int obs_op[$];
    int obs_val[$];
    int exp_jump, wcnt, nrd, njump, nexec, jaddr, xop, taddr, n;
    bit exp_exec, fin, aborted;
    exp_jump = 0; exp_exec = 0;
    if (!nmi) begin exp_op.push_back(0); exp_val.push_back(0); end
    if (!nmi && mode == 2'd0) exp_exec = 1;
    else begin
      exp_op.push_back(1); exp_val.push_back(int'(pc) / 256);
      exp_op.push_back(2); exp_val.push_back(int'(pc) % 256);
      if (nmi) exp_jump = 'h66;
      else if (mode == 2'd1) exp_jump = 'h38;
      else begin
        taddr = int'(ireg) * 256 + int'(vec);
        exp_op.push_back(3); exp_val.push_back(taddr);
        exp_op.push_back(3); exp_val.push_back((taddr + 1) % 65536);
        exp_jump = int'(hi) * 256 + int'(lo);
      end
    end
    wcnt = 0; nrd = 0; njump = 0; nexec = 0; jaddr = 0; xop = 0;
    fin = 0; aborted = 0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      step();
      if (jump_valid) begin njump++; jaddr = int'(jump_addr); end
      if (exec_valid) begin nexec++; xop = int'(exec_opcode); end
      if (bus_done) begin
        bus_done = 0;
        chk("bus_req_gap", bus_req, 0);
      end else if (bus_req) begin
        if (wcnt == 0 && obs_op.size() == abort_txn) begin
          reset = 1;
          #1;
          chk("abort_bus_req", bus_req, 0);
          chk("abort_busy", busy, 0);
          for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_no_jump", jump_valid, 0);
            chk("abort_idle", busy, 0);
          end
          reset = 0;
          aborted = 1;
          fin = 1;
        end else begin
          wcnt++;
          if (wcnt >= lat) begin
            obs_op.push_back(int'(bus_op));
            if (bus_op == 3'd1 || bus_op == 3'd2) obs_val.push_back(int'(bus_wdata));
            else if (bus_op == 3'd3) obs_val.push_back(int'(bus_addr));
            else obs_val.push_back(0);
            if (bus_op == 3'd0) bus_rdata = vec;
            else if (nrd == 0) bus_rdata = lo;
            else bus_rdata = hi;
            if (bus_op == 3'd3) nrd++;
            bus_done = 1;
            wcnt = 0;
          end
        end
      end
      if ((njump + nexec) > 0 && !busy && !bus_req && !bus_done) fin = 1;
    end
    if (abort_txn >= 0) begin
      chk("abort_reached", aborted, 1);
    end else begin
      chk("seq_done", fin, 1);
      chk("txn_count", obs_op.size(), exp_op.size());
      n = (obs_op.size() < exp_op.size()) ? obs_op.size() : exp_op.size();
      for (int i = 0; i < n; i++) begin
        chk("txn_op", obs_op[i], exp_op[i]);
        chk("txn_val", obs_val[i], exp_val[i]);
      end
      chk("jump_pulses", njump, exp_exec ? 0 : 1);
      chk("exec_pulses", nexec, exp_exec ? 1 : 0);
      if (exp_exec) chk("exec_opcode", xop, vec);
      else chk("jump_addr", jaddr, exp_jump);
    end
  endtask

  task automatic run_seq(input bit nmi, input logic [1:0] mode, input logic [15:0] pc,
                         input logic [7:0] ireg, input logic [7:0] vec, input logic [7:0] lo,
                         input logic [7:0] hi, input int lat, input int abort_txn);
    pc_in = pc;
    i_reg = ireg;
    int_req = 1;
    boundary = 1;
    step();
    boundary = 0;
    int_req = 0;
    chk("busy_after_accept", busy, 1);
    serve(nmi, mode, pc, ireg, vec, lo, hi, lat, abort_txn);
  endtask

  vec_t tbl[9];

  initial begin
    logic [1:0] m_mode;
    logic m_f1, m_f2, s0, s1, s2, se, sd, sr;
    int kind;
    logic [1:0] rmode;

    tbl[0] = '{0, 0, 0, 0, 0, 2'd0, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 0, 2'd2, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 0, 2'd0, 0, 0};
    tbl[3] = '{1, 1, 0, 0, 0, 2'd1, 0, 0};
    tbl[4] = '{0, 0, 0, 1, 0, 2'd1, 1, 1};
    tbl[5] = '{0, 0, 0, 0, 1, 2'd1, 0, 0};
    tbl[6] = '{0, 0, 0, 1, 1, 2'd1, 0, 0};
    tbl[7] = '{0, 0, 0, 1, 0, 2'd1, 1, 1};
    tbl[8] = '{1, 1, 1, 0, 0, 2'd2, 1, 1};

    step();
    chk("rst_im_mode", im_mode, 0);
    chk("rst_iff1", iff1, 0);
    chk("rst_iff2", iff2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_pulses", {jump_valid, exec_valid}, 0);
    chk("rst_regs", {bus_addr, jump_addr}, 0);
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      P2_IM0 = tbl[i].im0; P2_IM1 = tbl[i].im1; P2_IM2 = tbl[i].im2;
      ei = tbl[i].s_ei; di = tbl[i].s_di;
      step();
      P2_IM0 = 0; P2_IM1 = 0; P2_IM2 = 0; ei = 0; di = 0;
      chk("tbl_mode", im_mode, tbl[i].mode);
      chk("tbl_iff1", iff1, tbl[i].f1);
      chk("tbl_iff2", iff2, tbl[i].f2);
    end

    // randomized strobes against a rule model (no boundaries, so no acceptance)
    do_reset();
    m_mode = 0; m_f1 = 0; m_f2 = 0;
    for (int i = 0; i < 40; i++) begin
      s0 = 1'($urandom); s1 = 1'($urandom); s2 = 1'($urandom);
      se = ($urandom_range(0, 3) == 0); sd = ($urandom_range(0, 3) == 0);
      sr = !se && !sd && ($urandom_range(0, 3) == 0);
      P2_IM0 = s0; P2_IM1 = s1; P2_IM2 = s2; ei = se; di = sd; retn = sr;
      step();
      P2_IM0 = 0; P2_IM1 = 0; P2_IM2 = 0; ei = 0; di = 0; retn = 0;
      if (s2) m_mode = 2; else if (s1) m_mode = 1; else if (s0) m_mode = 0;
      if (sd) begin m_f1 = 0; m_f2 = 0; end
      else if (se) begin m_f1 = 1; m_f2 = 1; end
      else if (sr) m_f1 = m_f2;
      chk("rnd_mode", im_mode, m_mode);
      chk("rnd_iff1", iff1, m_f1);
      chk("rnd_iff2", iff2, m_f2);
    end

    // EI shadow: first boundary after EI must not accept
    do_reset();
    set_mode(2'd1);
    pc_in = 16'h1234;
    ei = 1;
    step();
    ei = 0;
    int_req = 1;
    boundary = 1;
    step();
    boundary = 0;
    chk("ei_block_no_accept", busy, 0);
    step();
    boundary = 1;
    step();
    boundary = 0;
    int_req = 0;
    chk("ei_accept_second", busy, 1);
    serve(0, 2'd1, 16'h1234, 8'h00, 8'hFF, 8'h00, 8'h00, 2, -1);

    // IM1 push and restart vector
    do_reset();
    set_mode(2'd1);
    enable_ints();
    run_seq(0, 2'd1, 16'h1234, 8'h00, 8'hFF, 8'h00, 8'h00, 2, -1);
    chk("im1_iff1", iff1, 0);
    chk("im1_iff2", iff2, 0);

    // IM2 table read and wrapped table read
    set_mode(2'd2);
    enable_ints();
    run_seq(0, 2'd2, 16'hBEEF, 8'h80, 8'hFF, 8'hCD, 8'hAB, 1, -1);
    enable_ints();
    run_seq(0, 2'd2, 16'h0102, 8'hFF, 8'hFF, 8'h11, 8'h22, 3, -1);

    // NMI beats INT at the same boundary, then RETN restores iff1
    enable_ints();
    nmi_req = 1;
    step();
    run_seq(1, 2'd2, 16'h4321, 8'h00, 8'h00, 8'h00, 8'h00, 2, -1);
    nmi_req = 0;
    chk("nmi_iff1", iff1, 0);
    chk("nmi_iff2", iff2, 1);
    retn = 1;
    step();
    retn = 0;
    chk("retn_iff1", iff1, 1);

    // reset while RD_HI is requesting
    set_mode(2'd2);
    enable_ints();
    run_seq(0, 2'd2, 16'h5555, 8'h40, 8'h10, 8'h01, 8'h02, 2, 4);
    chk("abort_im_mode", im_mode, 0);

    // randomized complete sequences
    m_f1 = 0;
    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 3);
      rmode = (kind == 3) ? 2'($urandom_range(0, 2)) : 2'(kind);
      set_mode(rmode);
      if (kind != 3 || $urandom_range(0, 1) == 1) begin
        enable_ints();
        m_f1 = 1;
      end
      if (kind == 3) begin
        nmi_req = 1;
        step();
      end
      run_seq(kind == 3, rmode, 16'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom), $urandom_range(1, 3), -1);
      nmi_req = 0;
      chk("rseq_iff1", iff1, 0);
      chk("rseq_iff2", iff2, (kind == 3) ? m_f1 : 1'b0);
      m_f1 = 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
